// File: rtl/mult_pipe_cell.sv
`default_nettype none
// ============================================================================
// Module      : mult_pipe_cell
// Description : Pipelined DATA_W x DATA_W integer multiply cell returning the
//               selected half of the 2*DATA_W-bit product.
//               Modes: 00 MUL (low half), 01 MULXUU, 10 MULXSS, 11 MULXSU
//               (high half, unsigned/signed operand interpretations).
//               The whole pipeline advances together under valid/ready
//               back-pressure; flush kills every in-flight beat.
// Ports       : clk        - clock, rising edge
//               reset_n    - synchronous active-low reset (clears all state)
//               flush      - synchronous pipeline kill
//               in_valid   - operand beat present
//               in_ready   - cell can accept a beat (= ~out_valid | out_ready)
//               in_op      - mode select
//               in_a/in_b  - operands
//               in_tag     - destination tag, returned with the result
//               out_valid  - result beat present
//               out_ready  - consumer takes result
//               out_result - selected product half
//               out_tag    - tag of the result
// Revision    : 1.0 - initial release
// ============================================================================
module mult_pipe_cell #(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag
);

    localparam int c_HALF_W = DATA_W / 2;

    localparam logic [DATA_W-1:0]   c_ZERO_W = '0;
    localparam logic [c_HALF_W-1:0] c_ZERO_H = '0;

    // ------------------------------------------------------------------------
    // Handshake: a single enable moves every stage at once
    // ------------------------------------------------------------------------
    logic w_advance;

    assign w_advance = ~out_valid | out_ready;
    assign in_ready  = w_advance;

    // ------------------------------------------------------------------------
    // Stage 1 inputs: half-width unsigned partial products and sign flags
    // ------------------------------------------------------------------------
    logic              w_a_signed;
    logic              w_b_signed;
    logic [DATA_W-1:0] w_a_lo;
    logic [DATA_W-1:0] w_a_hi;
    logic [DATA_W-1:0] w_b_lo;
    logic [DATA_W-1:0] w_b_hi;

    assign w_a_signed = in_op[1];
    assign w_b_signed = (in_op == 2'b10);

    // Halves are zero-extended to DATA_W so each product is computed at full
    // HALF_W x HALF_W precision without truncation.
    assign w_a_lo = {c_ZERO_H, in_a[c_HALF_W-1:0]};
    assign w_a_hi = {c_ZERO_H, in_a[DATA_W-1:c_HALF_W]};
    assign w_b_lo = {c_ZERO_H, in_b[c_HALF_W-1:0]};
    assign w_b_hi = {c_ZERO_H, in_b[DATA_W-1:c_HALF_W]};

    logic              r_s1_valid;
    logic [1:0]        r_s1_op;
    logic [TAG_W-1:0]  r_s1_tag;
    logic [DATA_W-1:0] r_s1_a;
    logic [DATA_W-1:0] r_s1_b;
    logic              r_s1_a_neg;
    logic              r_s1_b_neg;
    logic [DATA_W-1:0] r_pp_ll;
    logic [DATA_W-1:0] r_pp_lh;
    logic [DATA_W-1:0] r_pp_hl;
    logic [DATA_W-1:0] r_pp_hh;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= 2'b00;
            r_s1_tag   <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_a_neg <= 1'b0;
            r_s1_b_neg <= 1'b0;
            r_pp_ll    <= '0;
            r_pp_lh    <= '0;
            r_pp_hl    <= '0;
            r_pp_hh    <= '0;
        end else begin
            // Flush wins over a same-cycle beat, even when in_ready is high.
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_advance) begin
                r_s1_valid <= in_valid;
            end

            if (w_advance) begin
                r_s1_op    <= in_op;
                r_s1_tag   <= in_tag;
                r_s1_a     <= in_a;
                r_s1_b     <= in_b;
                r_s1_a_neg <= w_a_signed & in_a[DATA_W-1];
                r_s1_b_neg <= w_b_signed & in_b[DATA_W-1];
                r_pp_ll    <= w_a_lo * w_b_lo;
                r_pp_lh    <= w_a_lo * w_b_hi;
                r_pp_hl    <= w_a_hi * w_b_lo;
                r_pp_hh    <= w_a_hi * w_b_hi;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: recombine partial products, apply sign corrections
    // ------------------------------------------------------------------------
    // A negative signed operand X equals X_u - 2^DATA_W. Expanding the product
    // leaves -(other_u << DATA_W) per negative operand; the 2^(2*DATA_W) cross
    // term falls off the top of the 2*DATA_W-bit result.
    logic [2*DATA_W-1:0] w_sum_u;
    logic [2*DATA_W-1:0] w_corr_a;
    logic [2*DATA_W-1:0] w_corr_b;
    logic [2*DATA_W-1:0] w_product;
    logic [DATA_W-1:0]   w_s2_result;

    assign w_sum_u = {c_ZERO_W, r_pp_ll}
                   + {c_ZERO_H, r_pp_lh, c_ZERO_H}
                   + {c_ZERO_H, r_pp_hl, c_ZERO_H}
                   + {r_pp_hh, c_ZERO_W};

    assign w_corr_a  = r_s1_a_neg ? {r_s1_b, c_ZERO_W} : '0;
    assign w_corr_b  = r_s1_b_neg ? {r_s1_a, c_ZERO_W} : '0;
    assign w_product = w_sum_u - w_corr_a - w_corr_b;

    assign w_s2_result = (r_s1_op == 2'b00) ? w_product[DATA_W-1:0]
                                            : w_product[2*DATA_W-1:DATA_W];

    // ------------------------------------------------------------------------
    // Stages 2..PIPE_STAGES: result registers; index 2 is fed by the adder,
    // higher indices are pure delay.
    // ------------------------------------------------------------------------
    logic              r_valid  [2:PIPE_STAGES];
    logic [DATA_W-1:0] r_result [2:PIPE_STAGES];
    logic [TAG_W-1:0]  r_tag    [2:PIPE_STAGES];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 2; k <= PIPE_STAGES; k++) begin
                r_valid[k]  <= 1'b0;
                r_result[k] <= '0;
                r_tag[k]    <= '0;
            end
        end else begin
            if (flush) begin
                for (int k = 2; k <= PIPE_STAGES; k++) begin
                    r_valid[k] <= 1'b0;
                end
            end else if (w_advance) begin
                r_valid[2] <= r_s1_valid;
                for (int k = 3; k <= PIPE_STAGES; k++) begin
                    r_valid[k] <= r_valid[k-1];
                end
            end

            if (w_advance) begin
                r_result[2] <= w_s2_result;
                r_tag[2]    <= r_s1_tag;
                for (int k = 3; k <= PIPE_STAGES; k++) begin
                    r_result[k] <= r_result[k-1];
                    r_tag[k]    <= r_tag[k-1];
                end
            end
        end
    end

    assign out_valid  = r_valid[PIPE_STAGES];
    assign out_result = r_result[PIPE_STAGES];
    assign out_tag    = r_tag[PIPE_STAGES];

endmodule
`default_nettype wire

// File: tb/tb_mult_pipe_cell.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_pipe_cell
// Description : Directed self-checking bench for mult_pipe_cell. Instantiates
//               a 32-bit/2-stage cell and a 16-bit/4-stage cell sharing one
//               clock and reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mult_pipe_cell;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    // 32-bit, 2-stage instance
    logic        f32   = 1'b0;
    logic        iv32  = 1'b0;
    logic        ir32;
    logic [1:0]  op32  = 2'b00;
    logic [31:0] a32   = '0;
    logic [31:0] b32   = '0;
    logic [4:0]  tag32 = '0;
    logic        ov32;
    logic        or32  = 1'b1;
    logic [31:0] res32;
    logic [4:0]  otag32;

    // 16-bit, 4-stage instance
    logic        f16   = 1'b0;
    logic        iv16  = 1'b0;
    logic        ir16;
    logic [1:0]  op16  = 2'b00;
    logic [15:0] a16   = '0;
    logic [15:0] b16   = '0;
    logic [4:0]  tag16 = '0;
    logic        ov16;
    logic        or16  = 1'b1;
    logic [15:0] res16;
    logic [4:0]  otag16;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_pipe_cell #(.DATA_W(32), .PIPE_STAGES(2), .TAG_W(5)) dut32 (
        .clk(clk), .reset_n(reset_n), .flush(f32),
        .in_valid(iv32), .in_ready(ir32), .in_op(op32),
        .in_a(a32), .in_b(b32), .in_tag(tag32),
        .out_valid(ov32), .out_ready(or32),
        .out_result(res32), .out_tag(otag32)
    );

    mult_pipe_cell #(.DATA_W(16), .PIPE_STAGES(4), .TAG_W(5)) dut16 (
        .clk(clk), .reset_n(reset_n), .flush(f16),
        .in_valid(iv16), .in_ready(ir16), .in_op(op16),
        .in_a(a16), .in_b(b16), .in_tag(tag16),
        .out_valid(ov16), .out_ready(or16),
        .out_result(res16), .out_tag(otag16)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: extend operands per mode, multiply at 64 bits, pick a half.
    function automatic logic [15:0] ref16(input logic [1:0] op,
                                          input logic [15:0] a,
                                          input logic [15:0] b);
        longint     sa;
        longint     sb;
        longint     p;
        logic [63:0] pu;
        sa = op[1]          ? longint'($signed(a)) : longint'(a);
        sb = (op == 2'b10)  ? longint'($signed(b)) : longint'(b);
        p  = sa * sb;
        pu = p;
        return (op == 2'b00) ? pu[15:0] : pu[31:16];
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        checks++;
        if (ov32 !== 1'b0 || res32 !== 32'h0 || otag32 !== 5'd0) begin
            errors++;
            $display("FAIL reset32: valid=%b result=%h tag=%0d, required 0/0/0", ov32, res32, otag32);
        end
        checks++;
        if (ir32 !== 1'b1) begin
            errors++;
            $display("FAIL reset32_ready: in_ready=%b, required 1", ir32);
        end
        checks++;
        if (ov16 !== 1'b0 || res16 !== 16'h0 || otag16 !== 5'd0 || ir16 !== 1'b1) begin
            errors++;
            $display("FAIL reset16: valid=%b result=%h tag=%0d ready=%b, required 0/0/0/1", ov16, res16, otag16, ir16);
        end
    endtask

    task automatic test_mul_low();
        or32 = 1'b1; iv32 = 1'b1; op32 = 2'b00;
        a32 = 32'h0001_2345; b32 = 32'h0000_1000; tag32 = 5'd3;
        tick();
        iv32 = 1'b0;
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL mul_low_early: out_valid=%b after 1 cycle, required 0", ov32);
        end
        tick();
        checks++;
        if (ov32 !== 1'b1 || res32 !== 32'h1234_5000 || otag32 !== 5'd3) begin
            errors++;
            $display("FAIL mul_low: valid=%b result=%h tag=%0d, required 1/12345000/3", ov32, res32, otag32);
        end
        tick();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL mul_low_drain: out_valid=%b, required 0", ov32);
        end
    endtask

    task automatic test_mode_sweep();
        logic [1:0]  ops   [5];
        logic [31:0] opnd  [5];
        logic [31:0] exp_r [5];
        ops   = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
        opnd  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        exp_r = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h4000_0000};
        or32 = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            if (i < 5) begin
                iv32 = 1'b1; op32 = ops[i]; a32 = opnd[i]; b32 = opnd[i];
                tag32 = 5'(10 + i);
            end else begin
                iv32 = 1'b0;
            end
            tick();
            if (i >= 1) begin
                checks++;
                if (ov32 !== 1'b1 || res32 !== exp_r[i-1] || otag32 !== 5'(9 + i)) begin
                    errors++;
                    $display("FAIL mode_sweep[%0d]: valid=%b result=%h tag=%0d, required 1/%h/%0d",
                             i - 1, ov32, res32, otag32, exp_r[i-1], 9 + i);
                end
            end
        end
        tick();
        checks++;
        if (ov32 !== 1'b0) begin
            errors++;
            $display("FAIL mode_sweep_drain: out_valid=%b, required 0", ov32);
        end
    endtask

    task automatic test_back_pressure();
        int          sent = 0;
        int          rcv  = 0;
        int          stall_left = 0;
        bit          first_seen = 0;
        bit          acc;
        logic [31:0] held_res = '0;
        logic [4:0]  held_tag = '0;
        logic [31:0] exp_v;
        for (int cyc = 0; cyc < 60 && rcv < 6; cyc++) begin
            if (ov32 === 1'b1 && !first_seen) begin
                first_seen = 1;
                stall_left = 3;
                held_res   = res32;
                held_tag   = otag32;
            end
            or32 = (stall_left == 0);
            if (sent < 6) begin
                iv32 = 1'b1; op32 = 2'b00;
                a32 = 32'(sent + 1); b32 = 32'(sent + 2); tag32 = 5'(sent);
            end else begin
                iv32 = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                checks++;
                if (ir32 !== 1'b0 || res32 !== held_res || otag32 !== held_tag || ov32 !== 1'b1) begin
                    errors++;
                    $display("FAIL bp_stall: ready=%b valid=%b result=%h tag=%0d, required 0/1/%h/%0d",
                             ir32, ov32, res32, otag32, held_res, held_tag);
                end
                stall_left--;
            end
            acc = (iv32 && ir32);
            if (ov32 === 1'b1 && or32) begin
                exp_v = 32'((rcv + 1) * (rcv + 2));
                checks++;
                if (res32 !== exp_v || otag32 !== 5'(rcv)) begin
                    errors++;
                    $display("FAIL bp_result[%0d]: result=%h tag=%0d, required %h/%0d",
                             rcv, res32, otag32, exp_v, rcv);
                end
                rcv++;
            end
            tick();
            if (acc) sent++;
        end
        iv32 = 1'b0;
        or32 = 1'b1;
        checks++;
        if (rcv != 6 || !first_seen) begin
            errors++;
            $display("FAIL bp_count: received %0d beats, required 6", rcv);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (ov32 !== 1'b0) begin
                errors++;
                $display("FAIL bp_dup: out_valid=%b after stream end, required 0", ov32);
            end
        end
    endtask

    task automatic test_flush_stall();
        or32 = 1'b1; iv32 = 1'b1; op32 = 2'b00; a32 = 32'd3; b32 = 32'd5; tag32 = 5'd9;
        tick();
        iv32 = 1'b0;
        tick();
        or32 = 1'b0;
        f32  = 1'b1;
        #1;
        checks++;
        if (ov32 !== 1'b1 || ir32 !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall_pre: valid=%b ready=%b, required 1/0", ov32, ir32);
        end
        tick();
        f32 = 1'b0;
        checks++;
        if (ov32 !== 1'b0 || ir32 !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall: valid=%b ready=%b, required 0/1", ov32, ir32);
        end
        or32 = 1'b1;
    endtask

    task automatic test_flush();
        or16 = 1'b1; iv16 = 1'b1; op16 = 2'b00; a16 = 16'd2; b16 = 16'd3; tag16 = 5'd1;
        tick();
        tag16 = 5'd2; a16 = 16'd4;
        tick();
        tag16 = 5'd3; a16 = 16'd5; f16 = 1'b1;
        tick();
        f16 = 1'b0;
        op16 = 2'b01; a16 = 16'h1234; b16 = 16'h0100; tag16 = 5'd4;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) iv16 = 1'b0;
            if (k < 4) begin
                checks++;
                if (ov16 !== 1'b0) begin
                    errors++;
                    $display("FAIL flush_kill[%0d]: out_valid=%b tag=%0d, required 0", k, ov16, otag16);
                end
            end else begin
                checks++;
                if (ov16 !== 1'b1 || res16 !== 16'h0012 || otag16 !== 5'd4) begin
                    errors++;
                    $display("FAIL flush_next: valid=%b result=%h tag=%0d, required 1/0012/4", ov16, res16, otag16);
                end
            end
        end
        tick();
        checks++;
        if (ov16 !== 1'b0) begin
            errors++;
            $display("FAIL flush_drain: out_valid=%b, required 0", ov16);
        end
    endtask

    task automatic test_reset_mid();
        or32 = 1'b1; iv32 = 1'b1; op32 = 2'b00; a32 = 32'd7; b32 = 32'd7; tag32 = 5'd1;
        tick();
        tag32 = 5'd2;
        tick();
        tag32 = 5'd3; or32 = 1'b0; reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        iv32 = 1'b0;
        checks++;
        if (ov32 !== 1'b0 || res32 !== 32'h0 || otag32 !== 5'd0 || ir32 !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: valid=%b result=%h tag=%0d ready=%b, required 0/0/0/1",
                     ov32, res32, otag32, ir32);
        end
        or32 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (ov32 !== 1'b0) begin
                errors++;
                $display("FAIL reset_stale[%0d]: out_valid=%b tag=%0d, required 0", k, ov32, otag32);
            end
        end
    endtask

    task automatic test_param_small();
        or16 = 1'b1; iv16 = 1'b1; op16 = 2'b11; a16 = 16'h8000; b16 = 16'hFFFF; tag16 = 5'd17;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k == 1) iv16 = 1'b0;
            checks++;
            if (k < 4) begin
                if (ov16 !== 1'b0) begin
                    errors++;
                    $display("FAIL param_early[%0d]: out_valid=%b, required 0", k, ov16);
                end
            end else if (ov16 !== 1'b1 || res16 !== 16'h8000 || otag16 !== 5'd17) begin
                errors++;
                $display("FAIL param_su: valid=%b result=%h tag=%0d, required 1/8000/17", ov16, res16, otag16);
            end
        end
        tick();
    endtask

    task automatic test_random();
        logic [15:0] exp_res_q [$];
        logic [4:0]  exp_tag_q [$];
        logic [15:0] er;
        logic [4:0]  et;
        int          sent = 0;
        int          rcv  = 0;
        int          sel;
        for (int cyc = 0; cyc < 4000 && rcv < 200; cyc++) begin
            or16 = 1'($urandom_range(0, 1));
            if (sent < 200) begin
                iv16  = ($urandom_range(0, 3) != 0);
                op16  = 2'($urandom_range(0, 3));
                sel   = int'($urandom_range(0, 5));
                a16   = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
                sel   = int'($urandom_range(0, 5));
                b16   = (sel == 0) ? 16'h8000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
                tag16 = 5'(sent);
            end else begin
                iv16 = 1'b0;
            end
            #1;
            if (ov16 === 1'b1 && or16) begin
                checks++;
                if (exp_res_q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: unexpected result %h tag %0d, required none", res16, otag16);
                end else begin
                    er = exp_res_q.pop_front();
                    et = exp_tag_q.pop_front();
                    if (res16 !== er || otag16 !== et) begin
                        errors++;
                        $display("FAIL rand[%0d]: result=%h tag=%0d, required %h/%0d", rcv, res16, otag16, er, et);
                    end
                end
                rcv++;
            end
            if (iv16 && ir16) begin
                exp_res_q.push_back(ref16(op16, a16, b16));
                exp_tag_q.push_back(tag16);
                sent++;
            end
            tick();
        end
        iv16 = 1'b0;
        or16 = 1'b1;
        checks++;
        if (rcv != 200) begin
            errors++;
            $display("FAIL rand_count: received %0d beats, required 200", rcv);
        end
    endtask

    initial begin
        test_reset();
        test_mul_low();
        test_mode_sweep();
        test_back_pressure();
        test_flush_stall();
        test_flush();
        test_reset_mid();
        test_param_small();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mult_pipe_cell.md
# mult_pipe_cell

Parametrised, pipelined integer multiply cell for the Nios-class CPU datapath. It is the successor to the fixed 16x16 three-product multiplier cell. It accepts two DATA_W-bit operands plus an opcode and a destination tag, and returns the selected DATA_W-bit half of the full 2*DATA_W-bit product after PIPE_STAGES cycles. It covers the MUL, MULXUU, MULXSS and MULXSU modes, and adds valid/ready back-pressure and a pipeline flush.

## Interface
Parameters:
- DATA_W, 32: operand and result width; even, 8..32; HALF_W = DATA_W/2 is derived.
- PIPE_STAGES, 2: latency in cycles; 2..4.
- TAG_W, 5: width of the destination tag carried alongside the data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous pipeline kill.
- in_valid  in  1  operand beat present.
- in_ready  out  1  cell can accept a beat this cycle.
- in_op  in  2  mode: 00 MUL low, 01 MULXUU high unsigned, 10 MULXSS high signed x signed, 11 MULXSU high signed(a) x unsigned(b).
- in_a  in  DATA_W  operand A.
- in_b  in  DATA_W  operand B.
- in_tag  in  TAG_W  destination tag.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer takes result.
- out_result  out  DATA_W  selected product half.
- out_tag  out  TAG_W  tag of the result.

## Operation
- **Arithmetic:** each operand is extended to DATA_W+1 bits.
  - A is sign-extended for ops 10 and 11, zero-extended otherwise.
  - B is sign-extended for op 10 only.
  - The product P is the signed 2*DATA_W-bit result.
  - out_result = P[DATA_W-1:0] for op 00, otherwise P[2*DATA_W-1:DATA_W].
- **Stage 1:** registers the four HALF_W x HALF_W unsigned partial products (lo*lo, lo*hi, hi*lo, hi*hi), the operand sign bits, op and tag.
- **Stage 2:**
  - Sums the partial products with shifts of 0, HALF_W, HALF_W and DATA_W.
  - Subtracts the sign corrections: (B << DATA_W) if A is treated as signed and negative; (A << DATA_W) if B is treated as signed and negative.
  - Selects the half and registers it.
- **Stages 3..PIPE_STAGES:** pure delay registers carrying the valid, result and tag fields.
- **Handshake:** the pipeline advances as a whole.
  - advance = ~out_valid | out_ready.
  - in_ready = advance, combinational.
  - A beat is accepted when in_valid & in_ready.
  - When advance = 0, every stage holds; data and valids are frozen.
  - Bubbles are not compressed; an invalid stage still occupies its slot.
- **Flush:** on the next edge every stage valid is cleared. A beat presented in the same cycle is dropped, even if in_ready = 1. Data registers are not required to clear.
- **Reset:** every register clears to 0 on the edge at which reset_n = 0, including valids, data and tags. Reset overrides flush and acceptance. Reset mid-operation discards all in-flight beats.
- **Ordering:** results leave strictly in acceptance order. Each tag is returned unchanged with its own result.

## Timing
- **Reset values:** out_valid = 0, out_result = 0, out_tag = 0. in_ready = 1 after reset, since out_valid = 0.
- **Latency:** a beat accepted at edge N is presented with out_valid = 1 after edge N+PIPE_STAGES, provided no stall intervenes. Each stall cycle adds one cycle.
- **Throughput:** one beat per cycle while out_ready = 1.
- **Stall:**
  - out_valid = 1 with out_ready = 0 holds out_result and out_tag stable and drives in_ready = 0 in the same cycle.
  - Release takes effect at the first edge with out_ready = 1.
- **Simultaneous accept and drain** (out_ready = 1, in_valid = 1): both happen in one edge, with no bubble inserted.
- **Flush during stall:** all valids are cleared and the stall ends. out_valid = 0 from the next cycle.
- **Consumer behaviour:** out_ready is don't-care while out_valid = 0.
- **Combinational paths:** the only one is out_ready/out_valid -> in_ready. The path from in_valid to outputs is fully registered.

## Test plan
- **MUL low:** DATA_W=32, PIPE_STAGES=2; op 00, a=0x0001_2345, b=0x0000_1000, tag=3 -> out_valid exactly 2 cycles later, out_result=0x1234_5000, out_tag=3.
- **Mode sweep:** a=b=0xFFFF_FFFF issued back-to-back with ops 01, 10, 11, 00 -> four consecutive results 0xFFFF_FFFE, 0x0000_0000, 0xFFFF_FFFF, 0x0000_0001. Then op 10 with a=b=0x8000_0000 -> 0x4000_0000.
- **Back-pressure:**
  - Stream 6 beats (tags 0..5) while out_ready is held low for 3 cycles after the first result.
  - Required: no beat lost or duplicated; tags emerge 0..5 in order; out_result is stable throughout the stall; in_ready = 0 during the stall.
- **Flush:** with 2 beats in flight, assert flush together with a new in_valid beat -> no out_valid for either beat or the new one. A beat issued on the next cycle returns correctly after PIPE_STAGES cycles.
- **Reset mid-operation:** drop reset_n for 1 cycle with beats in flight -> after the edge, out_valid=0, out_result=0, out_tag=0, in_ready=1, and no stale result appears later.
- **Parameter sweep:** DATA_W=16, PIPE_STAGES=4; op 11, a=0x8000, b=0xFFFF -> 0x8000 after 4 cycles. Then 200 random beats with random out_ready are compared against a reference model for all modes.
